// File: rtl/cmat_pkg.sv
// Shared constants for the complex-matrix ping-pong buffer.
// PINGPONG_EN selects two banks; without it a single bank is used.
package cmat_pkg;

    localparam int CMAT_N     = 16;
    localparam int CMAT_ROWS  = 4;
    localparam int CMAT_COLS  = 2;
    localparam int CMAT_DEPTH = CMAT_ROWS * CMAT_COLS;
    localparam int CMAT_AW    = 3;

`ifdef PINGPONG_EN
    localparam int CMAT_NBANKS = 2;
`else
    localparam int CMAT_NBANKS = 1;
`endif

    function automatic logic [CMAT_AW-1:0] cmat_addr(input logic [1:0] row, input logic col);
        return {row, col};
    endfunction

endpackage

// File: rtl/cmat_bank.sv
// One matrix bank: 8-entry register file, synchronous write, asynchronous read.
module cmat_bank
    import cmat_pkg::*;
#(
    parameter int W = 2 * CMAT_N
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_we,
    input  logic [CMAT_AW-1:0] i_waddr,
    input  logic [W-1:0]       i_wdata,
    input  logic [CMAT_AW-1:0] i_raddr,
    output logic [W-1:0]       o_rdata
);

    logic [W-1:0] r_mem [CMAT_DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < CMAT_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cmatrix_pingpong_buffer.sv
// Stores one 4x2 complex matrix per frame and serves zero-latency random reads.
// PINGPONG_EN: two banks (fill one while the other is read); undefined: one bank.
module cmatrix_pingpong_buffer
    import cmat_pkg::*;
#(
    parameter int N = CMAT_N
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr_valid,
    output logic               o_wr_ready,
    input  logic [N-1:0]       i_wr_data_r,
    input  logic [N-1:0]       i_wr_data_i,
    input  logic               i_wr_last,
    output logic               o_rd_valid,
    input  logic [CMAT_AW-1:0] i_rd_addr,
    output logic [N-1:0]       o_rd_data_r,
    output logic [N-1:0]       o_rd_data_i,
    input  logic               i_rd_release,
    output logic               o_frame_err,
    output logic [1:0]         o_banks_full
);

    logic [CMAT_AW-1:0] r_wr_cnt;
    logic               r_frame_err;
    logic               w_accept;
    logic               w_frame_done;
    logic               w_release;
    logic [2*N-1:0]     w_wdata;
    logic [2*N-1:0]     w_rdata;

    assign w_accept     = i_wr_valid && o_wr_ready;
    assign w_frame_done = w_accept && (r_wr_cnt == CMAT_AW'(CMAT_DEPTH - 1));
    assign w_release    = i_rd_release && o_rd_valid;
    assign w_wdata      = {i_wr_data_r, i_wr_data_i};

`ifdef PINGPONG_EN
    logic [1:0]     r_full;
    logic           r_wr_bank;
    logic           r_rd_bank;
    logic [2*N-1:0] w_bank_rdata [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        cmat_bank #(.W(2 * N)) u_bank (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_we    (w_accept && (r_wr_bank == 1'(b))),
            .i_waddr (r_wr_cnt),
            .i_wdata (w_wdata),
            .i_raddr (i_rd_addr),
            .o_rdata (w_bank_rdata[b])
        );
    end

    assign w_rdata      = w_bank_rdata[r_rd_bank];
    assign o_wr_ready   = !r_full[r_wr_bank];
    assign o_rd_valid   = r_full[r_rd_bank];
    assign o_banks_full = {1'b0, r_full[0]} + {1'b0, r_full[1]};

    // Completion and release always target different banks, so both may land together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            if (w_frame_done) begin
                r_full[r_wr_bank] <= 1'b1;
                r_wr_bank         <= ~r_wr_bank;
            end
            if (w_release) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
        end
    end
`else
    logic r_full;

    cmat_bank #(.W(2 * N)) u_bank (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_accept),
        .i_waddr (r_wr_cnt),
        .i_wdata (w_wdata),
        .i_raddr (i_rd_addr),
        .o_rdata (w_rdata)
    );

    assign o_wr_ready   = !r_full;
    assign o_rd_valid   = r_full;
    assign o_banks_full = {1'b0, r_full};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_full <= 1'b0;
        end else if (w_frame_done) begin
            r_full <= 1'b1;
        end else if (w_release) begin
            r_full <= 1'b0;
        end
    end
`endif

    assign o_rd_data_r = w_rdata[2*N-1:N];
    assign o_rd_data_i = w_rdata[N-1:0];
    assign o_frame_err = r_frame_err;

    // Frame boundary follows the counter alone; a misplaced last only raises the flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_cnt    <= '0;
            r_frame_err <= 1'b0;
        end else if (w_accept) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
            if (i_wr_last != (r_wr_cnt == CMAT_AW'(CMAT_DEPTH - 1))) begin
                r_frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmatrix_pingpong_buffer.sv
// Self-checking bench for cmatrix_pingpong_buffer against a frame-queue reference model.
// Build with or without PINGPONG_EN; the bank count follows cmat_pkg.
module tb_cmatrix_pingpong_buffer;
    import cmat_pkg::*;

    localparam int N  = 16;
    localparam int NB = CMAT_NBANKS;
    localparam int FW = CMAT_DEPTH * 2 * N;

    logic                      clk;
    logic                      i_rst;
    logic                      i_wr_valid;
    logic                      o_wr_ready;
    logic [N-1:0]              i_wr_data_r;
    logic [N-1:0]              i_wr_data_i;
    logic                      i_wr_last;
    logic                      o_rd_valid;
    logic [CMAT_AW-1:0]        i_rd_addr;
    logic [N-1:0]              o_rd_data_r;
    logic [N-1:0]              o_rd_data_i;
    logic                      i_rd_release;
    logic                      o_frame_err;
    logic [1:0]                o_banks_full;

    int checks   = 0;
    int failures = 0;
    int stepNo   = 0;

    // Reference model: completed frames waiting for the consumer, plus the frame being filled.
    logic [FW-1:0] fullQ[$];
    logic [FW-1:0] mPart;
    int            mCnt;
    bit            mErr;

    cmatrix_pingpong_buffer #(.N(N)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_wr_valid   (i_wr_valid),
        .o_wr_ready   (o_wr_ready),
        .i_wr_data_r  (i_wr_data_r),
        .i_wr_data_i  (i_wr_data_i),
        .i_wr_last    (i_wr_last),
        .o_rd_valid   (o_rd_valid),
        .i_rd_addr    (i_rd_addr),
        .o_rd_data_r  (o_rd_data_r),
        .o_rd_data_i  (o_rd_data_i),
        .i_rd_release (i_rd_release),
        .o_frame_err  (o_frame_err),
        .o_banks_full (o_banks_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void modelReset();
        fullQ.delete();
        mPart = '0;
        mCnt  = 0;
        mErr  = 0;
    endfunction

    task automatic applyReset();
        i_rst        = 1'b1;
        i_wr_valid   = 1'b0;
        i_rd_release = 1'b0;
        modelReset();
        @(negedge clk);
        i_rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus; outputs are compared at the falling edge, the model advances at the rising edge.
    task automatic step(input logic v, input logic [N-1:0] re, input logic [N-1:0] im,
                        input logic last, input logic rel, input logic [CMAT_AW-1:0] addr);
        logic          expReady;
        logic [FW-1:0] f;
        logic [2*N-1:0] s;
        bit            acc;
        stepNo++;
        i_wr_valid   = v;
        i_wr_data_r  = re;
        i_wr_data_i  = im;
        i_wr_last    = last;
        i_rd_release = rel;
        i_rd_addr    = addr;
        @(negedge clk);
        expReady = (fullQ.size() < NB);
        checks++;
        if (o_wr_ready !== expReady) begin
            failures++;
            $display("[TB] FAIL step%0d wr_ready got=%b exp=%b", stepNo, o_wr_ready, expReady);
        end
        checks++;
        if (o_rd_valid !== (fullQ.size() > 0)) begin
            failures++;
            $display("[TB] FAIL step%0d rd_valid got=%b exp=%b", stepNo, o_rd_valid, fullQ.size() > 0);
        end
        checks++;
        if (o_banks_full !== 2'(fullQ.size())) begin
            failures++;
            $display("[TB] FAIL step%0d banks_full got=%0d exp=%0d", stepNo, o_banks_full, fullQ.size());
        end
        checks++;
        if (o_frame_err !== mErr) begin
            failures++;
            $display("[TB] FAIL step%0d frame_err got=%b exp=%b", stepNo, o_frame_err, mErr);
        end
        if (fullQ.size() > 0) begin
            f = fullQ[0];
            s = f[int'(addr)*2*N +: 2*N];
            checks++;
            if ({o_rd_data_r, o_rd_data_i} !== s) begin
                failures++;
                $display("[TB] FAIL step%0d rd_data[%0d] got=%h/%h exp=%h/%h", stepNo, addr,
                         o_rd_data_r, o_rd_data_i, s[2*N-1:N], s[N-1:0]);
            end
        end
        @(posedge clk);
        acc = v && expReady;
        if (rel && fullQ.size() > 0) void'(fullQ.pop_front());
        if (acc) begin
            if (last != (mCnt == CMAT_DEPTH - 1)) mErr = 1;
            mPart[mCnt*2*N +: 2*N] = {re, im};
            if (mCnt == CMAT_DEPTH - 1) begin
                fullQ.push_back(mPart);
                mCnt = 0;
            end else begin
                mCnt++;
            end
        end
        #1;
    endtask

    task automatic idle(input logic [CMAT_AW-1:0] addr);
        step(1'b0, '0, '0, 1'b0, 1'b0, addr);
    endtask

    task automatic writeFrame(input logic [N-1:0] base, input int lastPos);
        for (int k = 0; k < CMAT_DEPTH; k++) begin
            step(1'b1, base + N'(k), -(base + N'(k)), (k == lastPos), 1'b0, CMAT_AW'(k));
        end
    endtask

    task automatic test_reset();
        applyReset();
        for (int a = 0; a < CMAT_DEPTH; a += 3) begin
            i_rd_addr = CMAT_AW'(a);
            #2;
            checks++;
            if (o_wr_ready !== 1'b1 || o_rd_valid !== 1'b0 || o_banks_full !== 2'd0 ||
                o_frame_err !== 1'b0 || o_rd_data_r !== '0 || o_rd_data_i !== '0) begin
                failures++;
                $display("[TB] FAIL reset_state addr%0d got rdy=%b v=%b bf=%0d err=%b d=%h/%h exp 1 0 0 0 0/0",
                         a, o_wr_ready, o_rd_valid, o_banks_full, o_frame_err, o_rd_data_r, o_rd_data_i);
            end
        end
        idle('0);
    endtask

    task automatic test_single_frame();
        writeFrame(16'd1, CMAT_DEPTH - 1);
        idle(cmat_addr(2'd2, 1'b1));
        checks++;
        if (o_rd_valid !== 1'b1 || o_rd_data_r !== 16'sd6 || o_rd_data_i !== -16'sd6 || o_frame_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_frame got v=%b d=%h/%h err=%b exp v=1 d=0006/fffa err=0",
                     o_rd_valid, o_rd_data_r, o_rd_data_i, o_frame_err);
        end
    endtask

`ifdef PINGPONG_EN
    task automatic test_pingpong();
        step(1'b0, '0, '0, 1'b0, 1'b1, '0);
        writeFrame(16'h0100, CMAT_DEPTH - 1);
        writeFrame(16'h0200, CMAT_DEPTH - 1);
        idle(cmat_addr(2'd1, 1'b1));
        checks++;
        if (o_banks_full !== 2'd2 || o_wr_ready !== 1'b0 || o_rd_data_r !== 16'h0103) begin
            failures++;
            $display("[TB] FAIL pingpong_full got bf=%0d rdy=%b d=%h exp bf=2 rdy=0 d=0103",
                     o_banks_full, o_wr_ready, o_rd_data_r);
        end
        step(1'b0, '0, '0, 1'b0, 1'b1, '0);
        idle(cmat_addr(2'd1, 1'b1));
        checks++;
        if (o_rd_data_r !== 16'h0203 || o_wr_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pingpong_release got d=%h rdy=%b exp d=0203 rdy=1", o_rd_data_r, o_wr_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < CMAT_DEPTH - 1; k++) begin
            step(1'b1, 16'h0300 + N'(k), 16'h0000, 1'b0, 1'b0, '0);
        end
        step(1'b1, 16'h0307, 16'h0000, 1'b1, 1'b1, '0);
        idle(3'd2);
        checks++;
        if (o_banks_full !== 2'd1 || o_rd_valid !== 1'b1 || o_rd_data_r !== 16'h0302) begin
            failures++;
            $display("[TB] FAIL back_to_back got bf=%0d v=%b d=%h exp bf=1 v=1 d=0302",
                     o_banks_full, o_rd_valid, o_rd_data_r);
        end
        step(1'b0, '0, '0, 1'b0, 1'b1, '0);
    endtask
`else
    task automatic test_single_bank();
        step(1'b0, '0, '0, 1'b0, 1'b1, '0);
        writeFrame(16'h0400, CMAT_DEPTH - 1);
        for (int h = 0; h < 3; h++) begin
            step(1'b1, 16'h7777, 16'h7777, 1'b0, 1'b0, 3'd4);
        end
        checks++;
        if (o_wr_ready !== 1'b0 || o_rd_data_r !== 16'h0404) begin
            failures++;
            $display("[TB] FAIL single_bank_hold got rdy=%b d=%h exp rdy=0 d=0404", o_wr_ready, o_rd_data_r);
        end
        step(1'b0, '0, '0, 1'b0, 1'b1, '0);
        checks++;
        if (o_wr_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_bank_release got rdy=%b exp rdy=1", o_wr_ready);
        end
    endtask
`endif

    task automatic test_frame_err();
        applyReset();
        step(1'b0, '0, '0, 1'b0, 1'b1, '0);
        writeFrame(16'h0500, 4);
        idle(3'd7);
        checks++;
        if (o_frame_err !== 1'b1 || o_rd_valid !== 1'b1 || o_rd_data_r !== 16'h0507) begin
            failures++;
            $display("[TB] FAIL frame_err got err=%b v=%b d=%h exp err=1 v=1 d=0507",
                     o_frame_err, o_rd_valid, o_rd_data_r);
        end
        step(1'b0, '0, '0, 1'b0, 1'b1, '0);
        idle('0);
        checks++;
        if (o_frame_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL frame_err_sticky got=%b exp=1", o_frame_err);
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 16'h0600 + N'(k), 16'h0000, 1'b0, 1'b0, '0);
        end
        applyReset();
        i_rd_addr = 3'd1;
        #1;
        checks++;
        if (o_wr_ready !== 1'b1 || o_rd_valid !== 1'b0 || o_rd_data_r !== '0 || o_rd_data_i !== '0) begin
            failures++;
            $display("[TB] FAIL mid_reset got rdy=%b v=%b d=%h/%h exp rdy=1 v=0 d=0/0",
                     o_wr_ready, o_rd_valid, o_rd_data_r, o_rd_data_i);
        end
        writeFrame(16'h0700, CMAT_DEPTH - 1);
        idle(3'd0);
        checks++;
        if (o_rd_data_r !== 16'h0700 || o_frame_err !== 1'b0 || o_banks_full !== 2'd1) begin
            failures++;
            $display("[TB] FAIL mid_reset_frame got d=%h err=%b bf=%0d exp d=0700 err=0 bf=1",
                     o_rd_data_r, o_frame_err, o_banks_full);
        end
    endtask

    task automatic test_random();
        logic v;
        logic last;
        applyReset();
        for (int c = 0; c < 400; c++) begin
            v    = ($urandom_range(0, 3) != 0);
            last = (mCnt == CMAT_DEPTH - 1);
            if ($urandom_range(0, 31) == 0) last = ~last;
            step(v, N'($urandom), N'($urandom), last, ($urandom_range(0, 3) == 0),
                 CMAT_AW'($urandom_range(0, CMAT_DEPTH - 1)));
        end
    endtask

    initial begin
        i_rst        = 1'b1;
        i_wr_valid   = 1'b0;
        i_wr_data_r  = '0;
        i_wr_data_i  = '0;
        i_wr_last    = 1'b0;
        i_rd_addr    = '0;
        i_rd_release = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
`ifdef PINGPONG_EN
        test_pingpong();
        test_back_to_back();
`else
        test_single_bank();
`endif
        test_frame_err();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
